// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding, word geometry and the
// fetch-target legality rule.
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT,
        FAULT
    } fetch_state_t;

    typedef logic [XLEN:0] xlen_ext_t;

    // Compare with one extra bit so depth*4 cannot overflow the address width.
    function automatic logic fetch_addr_legal(input logic [XLEN-1:0] addr,
                                              input int unsigned     depth_words);
        xlen_ext_t limit;
        limit = xlen_ext_t'(depth_words) * xlen_ext_t'(INSTR_BYTES);
        return (addr[1:0] == 2'b00) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC mux (jump > branch > sequential) plus the alignment/range check on
// the selected target.
module next_pc_select
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH_WORDS = 64
) (
    input  logic [XLEN-1:0] pc,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc,
    output logic            next_illegal
);

    always_comb begin
        pc_plus4 = pc + XLEN'(INSTR_BYTES);
        if (jump_valid) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else begin
            next_pc = pc_plus4;
        end
        next_illegal = !fetch_addr_legal(next_pc, IMEM_DEPTH_WORDS);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control: holds the architectural PC, steps it through the
// BOOT/RUN/HALT/FAULT lifecycle, and counts retired instructions.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR     = 32'h0000_0000,
    parameter int unsigned     IMEM_DEPTH_WORDS = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    input  logic            halt_req,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    output logic            halted,
    output logic            fault,
    output logic [XLEN-1:0] fault_addr,
    output logic [XLEN-1:0] retired_count
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] retired_q, retired_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
    logic            fault_q, fault_d;
    logic            halted_q, halted_d;

    logic [XLEN-1:0] next_pc;
    logic            next_illegal;

    next_pc_select #(
        .IMEM_DEPTH_WORDS(IMEM_DEPTH_WORDS)
    ) u_next_pc_select (
        .pc           (pc_q),
        .jump_valid   (jump_valid),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc),
        .next_illegal (next_illegal)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        retired_d    = retired_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        halted_d     = halted_q;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    // The halting instruction itself retires.
                    state_d   = HALT;
                    halted_d  = 1'b1;
                    retired_d = retired_q + 1'b1;
                end else if (!stall) begin
                    if (next_illegal) begin
                        state_d      = FAULT;
                        fault_d      = 1'b1;
                        fault_addr_d = next_pc;
                    end else begin
                        pc_d      = next_pc;
                        retired_d = retired_q + 1'b1;
                    end
                end
            end
            HALT, FAULT: begin
                // Frozen until reset.
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            retired_q    <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            retired_q    <= retired_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            halted_q     <= halted_d;
        end
    end

    assign pc            = pc_q;
    assign instr_valid   = (state_q == RUN);
    assign halted        = halted_q;
    assign fault         = fault_q;
    assign fault_addr    = fault_addr_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand-written corner sequences and a
// randomized run against a simple architectural model.
module tb_pc_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] LIMIT = 32'd256;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump_valid, halt_req;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc, pc_plus4, fault_addr, retired_count;
    logic        instr_valid, halted, fault;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_VECTOR    (RV),
        .IMEM_DEPTH_WORDS(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump_valid   (jump_valid),
        .jump_target  (jump_target),
        .halt_req     (halt_req),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .fault        (fault),
        .fault_addr   (fault_addr),
        .retired_count(retired_count)
    );

    logic [31:0] imem [DEPTH];

    int unsigned tests = 0;
    int unsigned fails = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jv;
        logic [31:0] jt;
        logic        halt;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_ret;
        logic        e_halted;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vt [14];

    // Architectural model state: 0 boot, 1 run, 2 halt, 3 fault.
    int          m_st;
    logic [31:0] m_pc, m_ret, m_faddr, m_tgt;
    logic        m_fault, m_halted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump_valid = 1'b0; halt_req = 1'b0;
        branch_target = '0; jump_target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic s, input logic br, input logic [31:0] bt,
                                input logic jv, input logic [31:0] jt, input logic h,
                                input logic [31:0] e_pc, input logic e_valid,
                                input logic [31:0] e_ret, input logic e_halted,
                                input logic [31:0] e_instr);
        vec_t v;
        v.stall = s; v.br = br; v.bt = bt; v.jv = jv; v.jt = jt; v.halt = h;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_ret = e_ret; v.e_halted = e_halted;
        v.e_instr = e_instr;
        return v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_pc = RV; m_ret = 0; m_faddr = 0; m_fault = 0; m_halted = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (halt_req) begin
                m_st = 2; m_halted = 1; m_ret = m_ret + 1;
            end else if (!stall) begin
                m_tgt = jump_valid ? jump_target : (branch_taken ? branch_target : m_pc + 4);
                if ((m_tgt % 4 == 0) && (m_tgt < LIMIT)) begin
                    m_pc = m_tgt; m_ret = m_ret + 1;
                end else begin
                    m_st = 3; m_fault = 1; m_faddr = m_tgt;
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_target();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'hFFFF_FFFC;
        if (r == 1) return 32'($urandom_range(0, 255));
        return 32'($urandom_range(0, 66)) * 4;
    endfunction

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) imem[i] = NOP_INSTR;
        imem[1] = 32'h0040_0093;
        imem[2] = 32'h00C0_0113;
        imem[3] = 32'h0020_81B3;
        imem[4] = 32'h0031_2023;

        //        stall br  bt     jv  jt     halt  pc     v  ret h  instr
        vt[0]  = mk(0, 0, 0,     0, 0,     0,  32'h00, 1, 0,  0, 32'h0000_0013);
        vt[1]  = mk(0, 0, 0,     0, 0,     0,  32'h04, 1, 1,  0, 32'h0040_0093);
        vt[2]  = mk(0, 0, 0,     0, 0,     0,  32'h08, 1, 2,  0, 32'h00C0_0113);
        vt[3]  = mk(0, 0, 0,     0, 0,     0,  32'h0C, 1, 3,  0, 32'h0020_81B3);
        vt[4]  = mk(0, 0, 0,     0, 0,     0,  32'h10, 1, 4,  0, 32'h0031_2023);
        vt[5]  = mk(0, 0, 0,     1, 32'h4, 0,  32'h04, 1, 5,  0, 32'h0040_0093);
        vt[6]  = mk(0, 0, 0,     1, 32'h10, 0, 32'h10, 1, 6,  0, 32'h0031_2023);
        vt[7]  = mk(0, 1, 32'h8, 1, 32'h14, 0, 32'h14, 1, 7,  0, 32'h0000_0013);
        vt[8]  = mk(0, 1, 32'h8, 0, 0,     0,  32'h08, 1, 8,  0, 32'h00C0_0113);
        vt[9]  = mk(1, 1, 32'h20, 0, 0,    0,  32'h08, 1, 8,  0, 32'h00C0_0113);
        vt[10] = mk(1, 1, 32'h20, 0, 0,    0,  32'h08, 1, 8,  0, 32'h00C0_0113);
        vt[11] = mk(1, 1, 32'h20, 0, 0,    0,  32'h08, 1, 8,  0, 32'h00C0_0113);
        vt[12] = mk(0, 0, 0,     0, 0,     0,  32'h0C, 1, 9,  0, 32'h0020_81B3);
        vt[13] = mk(0, 0, 0,     0, 0,     1,  32'h0C, 0, 10, 1, 32'h0020_81B3);

        // Reset lands in BOOT.
        do_reset();
        check("boot_pc", pc, RV);
        check("boot_valid", instr_valid, 0);
        check("boot_ret", retired_count, 0);
        check("boot_fault", fault, 0);
        check("boot_halted", halted, 0);

        for (int i = 0; i < 14; i++) begin
            idle();
            stall = vt[i].stall; branch_taken = vt[i].br; branch_target = vt[i].bt;
            jump_valid = vt[i].jv; jump_target = vt[i].jt; halt_req = vt[i].halt;
            tick();
            check($sformatf("vec%0d_pc", i), pc, vt[i].e_pc);
            check($sformatf("vec%0d_pc_plus4", i), pc_plus4, vt[i].e_pc + 32'd4);
            check($sformatf("vec%0d_valid", i), instr_valid, vt[i].e_valid);
            check($sformatf("vec%0d_ret", i), retired_count, vt[i].e_ret);
            check($sformatf("vec%0d_halted", i), halted, vt[i].e_halted);
            check($sformatf("vec%0d_fault", i), fault, 0);
            check($sformatf("vec%0d_instr", i), imem[pc[7:2]], vt[i].e_instr);
        end

        // Halt is frozen against any further requests.
        for (int i = 0; i < 10; i++) begin
            idle();
            stall = 1'($urandom); branch_taken = 1'b1; branch_target = 32'h20;
            jump_valid = 1'($urandom); jump_target = 32'h3; halt_req = 1'($urandom);
            tick();
            check("halt_pc", pc, 32'h0C);
            check("halt_ret", retired_count, 10);
            check("halt_flag", halted, 1);
            check("halt_valid", instr_valid, 0);
            check("halt_fault", fault, 0);
        end

        // Misaligned branch target faults; halt_req is then ignored.
        do_reset();
        tick();
        branch_taken = 1'b1; branch_target = 32'h3;
        tick();
        check("mis_fault", fault, 1);
        check("mis_faddr", fault_addr, 32'h3);
        check("mis_pc", pc, RV);
        check("mis_valid", instr_valid, 0);
        check("mis_ret", retired_count, 0);
        idle();
        halt_req = 1'b1;
        tick();
        check("mis_halt_ignored", halted, 0);
        check("mis_fault_sticky", fault, 1);

        // Sequential advance past the last word faults instead of wrapping.
        do_reset();
        check("rst_clears_fault", fault, 0);
        check("rst_clears_faddr", fault_addr, 0);
        tick();
        jump_valid = 1'b1; jump_target = 32'hFC;
        tick();
        check("end_pc", pc, 32'hFC);
        idle();
        tick();
        check("end_fault", fault, 1);
        check("end_faddr", fault_addr, 32'h100);
        check("end_pc_held", pc, 32'hFC);
        check("end_ret", retired_count, 1);

        // Reset mid-run.
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        check("mid_pc", pc, 32'h10);
        rst = 1'b1; jump_valid = 1'b1; jump_target = 32'h20;
        tick();
        check("mid_rst_pc", pc, RV);
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_ret", retired_count, 0);
        idle();
        tick();
        check("mid_rst_run_valid", instr_valid, 1);
        check("mid_rst_run_pc", pc, RV);

        // Randomized run against the model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 47) == 0);
            halt_req      = ($urandom_range(0, 39) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 2) == 0);
            jump_valid    = ($urandom_range(0, 3) == 0);
            branch_target = rand_target();
            jump_target   = rand_target();
            model_step();
            tick();
            check("rnd_pc", pc, m_pc);
            check("rnd_pc_plus4", pc_plus4, m_pc + 32'd4);
            check("rnd_valid", instr_valid, (m_st == 1));
            check("rnd_halted", halted, m_halted);
            check("rnd_fault", fault, m_fault);
            check("rnd_faddr", fault_addr, m_faddr);
            check("rnd_ret", retired_count, m_ret);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and fetch-control stage that sits directly upstream of InstructionMemory. It holds the architectural PC and drives it as the instruction-memory address. It selects the next PC from sequential, branch or jump sources. It also detects illegal fetch targets and tracks run, halt and fault state for the single-cycle core.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
IMEM_DEPTH_WORDS, 64, number of 32-bit words in instruction memory; legal fetch range is 0 .. IMEM_DEPTH_WORDS*4-4.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  hold PC and counters this cycle.
branch_taken  input  1  conditional branch resolved taken.
branch_target  input  32  branch destination byte address.
jump_valid  input  1  JAL/JALR redirect.
jump_target  input  32  jump destination byte address.
halt_req  input  1  request to stop fetching (ecall/ebreak decode).
pc  output  32  current PC; connects to InstructionMemory address.
pc_plus4  output  32  pc + 4, mod 2^32, combinational; used for link register.
instr_valid  output  1  fetched instruction is architecturally valid this cycle.
halted  output  1  core stopped by halt_req.
fault  output  1  sticky illegal-fetch flag.
fault_addr  output  32  offending target address.
retired_count  output  32  count of instructions retired.

Behaviour:
- States: BOOT, RUN, HALT, FAULT.
- Reset (rst=1 at a rising edge), from any state and mid-operation:
  - pc=RESET_VECTOR, state=BOOT.
  - instr_valid=0, halted=0, fault=0, fault_addr=0, retired_count=0.
- BOOT: lasts exactly one cycle, with instr_valid=0 and pc held, then moves to RUN. This gives one cycle for the memory image to settle.
- RUN: instr_valid=1. Per edge, the priority is halt_req > stall > jump_valid > branch_taken > sequential.
  - halt_req: go to HALT; pc held; retired_count+1 (the halting instruction retires).
  - stall: pc, state and retired_count all held.
  - Otherwise: next = jump_target, else branch_target, else pc+4.
  - If next is legal: pc <= next and retired_count+1.
  - Legality check: next[1:0]==2'b00 and next < IMEM_DEPTH_WORDS*4.
  - If next is illegal: go to FAULT, fault<=1, fault_addr<=next, pc held, retired_count not incremented.
  - The legality check also applies to sequential pc+4 at the end of memory; there is no wrap to 0.
- HALT: halted=1, instr_valid=0. pc, counters and fault are frozen. Only rst exits.
- FAULT: fault=1, instr_valid=0. All other state is frozen. Only rst exits; halt_req is ignored.
- Latency: a redirect presented in cycle N appears on pc in cycle N+1.
- Simultaneous jump_valid and branch_taken: jump wins. A stall coincident with a redirect drops the redirect; upstream must re-present it.
- retired_count wraps modulo 2^32.
- Outputs are registered except pc_plus4 and instr_valid, which decode from pc and state.

Decomposition:
- Package fetch_pkg:
  - typedef enum fetch_state_t {BOOT, RUN, HALT, FAULT}.
  - XLEN=32, INSTR_BYTES=4, NOP_INSTR=32'h0000_0013.
- One combinational sub-module, next_pc_select:
  - Performs the priority mux and the alignment/range check.
  - Outputs next_pc and next_illegal.
  - The FSM and registers remain in pc_fetch_unit.

Test Plan:
1. Reset then free-run, with pc_fetch_unit wired to InstructionMemory:
   - BOOT cycle with pc=0x0 and instr_valid=0.
   - Then pc 0x0, 0x4, 0x8, 0xC, 0x10 fetch 0x00000013, 0x00400093, 0x00C00113, 0x002081B3, 0x00312023.
   - retired_count=4 after 0x10 is reached.
2. Redirects:
   - jump_valid=1 with jump_target=0x10 at pc=0x4: next pc=0x10.
   - Simultaneous branch_taken (target 0x8) and jump (target 0x14): pc=0x14.
   - pc_plus4 at 0x14 is 0x18.
3. Stall:
   - stall=1 for 3 cycles at pc=0x8: pc stays 0x8 and retired_count is unchanged.
   - A branch presented during the stall is dropped; the next pc is 0xC.
4. Faults:
   - branch_target=0x3: fault=1, fault_addr=0x3, pc held, instr_valid=0.
   - After rst, a sequential advance past 0xFC (depth 64): fault_addr=0x100.
5. Halt: halt_req at pc=0xC gives halted=1, pc held at 0xC, retired_count+1, and no further change over 10 cycles.
6. rst asserted mid-RUN at pc=0x10: next cycle pc=RESET_VECTOR, state BOOT, all flags and counters cleared.
